regfile_scoreboard: RTL

//  Parametrised multi-read-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_busy_tracker.sv | 72 +++++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the register file / busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read bypass, see top).
package regfile_pkg;

    // Default architectural data width
    localparam int XLEN_DEF = 32;

    // Widest busy vector the popcount helper accepts (NREGS must not exceed this)
    localparam int POP_MAX = 256;

    typedef logic [XLEN_DEF-1:0] reg_word_t;
    typedef logic [4:0]          reg_addr_t;

    // Architectural zero register
    localparam reg_addr_t REG_ZERO = 5'd0;

    // Number of set bits in a (zero-extended) busy vector
    function automatic int popcount(input logic [POP_MAX-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            cnt = cnt + int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard: reservations from decode set a bit, writeback
// releases it, flush clears everything. Entry 0 is never busy.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_o,
    output logic             rsv_ready,
    output logic [AW:0]      busy_count
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             wr_rel_s;
    logic             rsv_take_s;

    // Reservation acceptance and next busy vector. A writeback releasing the
    // very register being reserved frees it in the same cycle, so the new
    // reservation is accepted and wins (busy ends set).
    always_comb begin
        wr_rel_s   = wr_en && (wr_addr != {AW{1'b0}});
        rsv_ready  = (rsv_addr == {AW{1'b0}}) || !busy_q[rsv_addr]
                     || (wr_rel_s && (wr_addr == rsv_addr));
        rsv_take_s = rsv_en && rsv_ready && (rsv_addr != {AW{1'b0}});

        busy_d = busy_q;
        if (wr_rel_s) begin
            busy_d[wr_addr] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (rsv_take_s) begin
            busy_d[rsv_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (flush) begin
            busy_d = {NREGS{1'b0}};
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;

        count_d = (AW+1)'(popcount(POP_MAX'(busy_d)));
    end

    // Busy vector and its registered population count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q  <= {NREGS{1'b0}};
            count_q <= {(AW+1){1'b0}};
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with registered reads and a busy
// scoreboard (regfile_busy_tracker). Entry 0 reads as zero and ignores writes.
// Macro REGFILE_BYPASS_EN: a read of the register being written this cycle
// returns the new data with busy 0 (write-first); otherwise read-first.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = 32,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_RD-1:0]      rd_en,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_valid,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   rsv_ready,
    input  logic                   flush,
    output logic [AW:0]            busy_count
);

    logic [XLEN-1:0]        mem_q [NREGS];
    logic [NREGS-1:0]       busy_s;
    logic [AW-1:0]          addr_s [NUM_RD];
    logic [NUM_RD*XLEN-1:0] rd_data_q;
    logic [NUM_RD*XLEN-1:0] rd_data_d;
    logic [NUM_RD-1:0]      rd_valid_q;
    logic [NUM_RD-1:0]      rd_valid_d;
    logic [NUM_RD-1:0]      rd_busy_q;
    logic [NUM_RD-1:0]      rd_busy_d;

    regfile_busy_tracker #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .flush      (flush),
        .busy_o     (busy_s),
        .rsv_ready  (rsv_ready),
        .busy_count (busy_count)
    );

    // Register storage; entry 0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= {XLEN{1'b0}};
            end
        end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Per-port read data, valid and sampled busy bit for the next cycle
    always_comb begin
        rd_data_d  = {(NUM_RD*XLEN){1'b0}};
        rd_valid_d = {NUM_RD{1'b0}};
        rd_busy_d  = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            addr_s[i] = rd_addr[i*AW +: AW];
            if (!rd_en[i]) begin
                rd_valid_d[i] = 1'b0;
            end else if (addr_s[i] == {AW{1'b0}}) begin
                rd_valid_d[i] = 1'b1;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en && (wr_addr == addr_s[i])) begin
                rd_valid_d[i]              = 1'b1;
                rd_data_d[i*XLEN +: XLEN] = wr_data;
                rd_busy_d[i]               = 1'b0;
`endif
            end else begin
                rd_valid_d[i]              = 1'b1;
                rd_data_d[i*XLEN +: XLEN] = mem_q[addr_s[i]];
                rd_busy_d[i]               = busy_s[addr_s[i]];
            end
        end
    end

    // Registered read outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q  <= {(NUM_RD*XLEN){1'b0}};
            rd_valid_q <= {NUM_RD{1'b0}};
            rd_busy_q  <= {NUM_RD{1'b0}};
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_busy  = rd_busy_q;

endmodule
